// File: rtl/axi_lite_master_seq.sv
`default_nettype none
// ==========================================================================
// axi_lite_master_seq : single-outstanding AXI4-Lite write / read-check master
// Rev 1.0
// ==========================================================================
module axi_lite_master_seq #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [DATA_W-1:0]   cmd_mask,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_mismatch,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY,
  output logic                busy,
  output logic                halted,
  output logic [CNT_W-1:0]    wr_count,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    err_count
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5,
    HALT  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d, mask_q, mask_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_mis_q, rsp_mis_d, rsp_to_q, rsp_to_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [CNT_W-1:0]    wr_q, wr_d, rd_q, rd_d, err_q, err_d;

  logic                aw_hs, w_hs, to_hit, fin, fin_mis, to_fire;
  logic [1:0]          fin_resp;
  logic [DATA_W-1:0]   fin_rdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign cmd_ready = (state_q == IDLE) & ~rst;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    strb_d      = strb_q;
    mask_d      = mask_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    to_d        = to_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_to_d    = rsp_to_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    err_d       = err_q;
    fin         = 1'b0;
    fin_resp    = 2'b00;
    fin_rdata   = '0;
    fin_mis     = 1'b0;
    to_fire     = 1'b0;
    aw_hs       = awvalid_q & M_AXI_AWREADY;
    w_hs        = wvalid_q & M_AXI_WREADY;
    to_hit      = (to_q == TO_W'(TIMEOUT));

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          strb_d  = cmd_strb;
          mask_d  = cmd_mask;
          to_d    = '0;
          if (cmd_write) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // A dropped VALID doubles as the "channel done" flag.
        to_d = to_q + TO_W'(1);
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) state_d = WRESP;
        else if (to_hit) to_fire = 1'b1;
      end
      WRESP: begin
        to_d = to_q + TO_W'(1);
        if (M_AXI_BVALID) begin
          fin      = 1'b1;
          fin_resp = M_AXI_BRESP;
        end else if (to_hit) to_fire = 1'b1;
      end
      RADDR: begin
        to_d = to_q + TO_W'(1);
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end else if (to_hit) to_fire = 1'b1;
      end
      RDATA: begin
        to_d = to_q + TO_W'(1);
        if (M_AXI_RVALID) begin
          fin       = 1'b1;
          fin_resp  = M_AXI_RRESP;
          fin_rdata = M_AXI_RDATA;
          fin_mis   = |((M_AXI_RDATA ^ data_q) & mask_q);
        end else if (to_hit) to_fire = 1'b1;
      end
      DONE:    state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Counters move on entry to DONE so they are current while rsp_valid is high.
    if (fin) begin
      state_d     = DONE;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = fin_rdata;
      rsp_resp_d  = fin_resp;
      rsp_mis_d   = fin_mis;
      rsp_to_d    = 1'b0;
      if (write_q) wr_d = sat_inc(wr_q);
      else         rd_d = sat_inc(rd_q);
      if ((fin_resp != 2'b00) || fin_mis) err_d = sat_inc(err_q);
    end

    if (to_fire) begin
      state_d     = HALT;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_resp_d  = 2'b10;
      rsp_mis_d   = 1'b0;
      rsp_to_d    = 1'b1;
      err_d       = sat_inc(err_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      mask_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      to_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      rsp_mis_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      mask_q      <= mask_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      to_q        <= to_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_to_q    <= rsp_to_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
    end
  end

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WSTRB   = strb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == WRESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == RDATA);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_mismatch  = rsp_mis_q;
  assign rsp_timeout   = rsp_to_q;
  assign busy          = (state_q != IDLE);
  assign halted        = (state_q == HALT);
  assign wr_count      = wr_q;
  assign rd_count      = rd_q;
  assign err_count     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_seq.sv
`default_nettype none
// ==========================================================================
// tb_axi_lite_master_seq : scoreboard bench with a reactive AXI4-Lite slave
// Rev 1.0
// ==========================================================================
module tb_axi_lite_master_seq;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data, cmd_mask;
  logic [3:0]    cmd_strb;
  logic          rsp_valid, rsp_mismatch, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]    M_AXI_WSTRB;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;
  logic          busy, halted;
  logic [CW-1:0] wr_count, rd_count, err_count;

  axi_lite_master_seq #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_mismatch(rsp_mismatch), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .busy(busy), .halted(halted),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        mis;
    logic        tmo;
    int          lat;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mem [0:1023];

  // Slave behaviour knobs
  int          aw_delay = 0;
  int          w_delay = 0;
  bit          b_never = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic [1:0]  r_resp_cfg = 2'b00;
  int          n_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic [1:0] rs,
                              input logic mi, input logic tm, input int lat);
    exp_t e;
    e.rdata = rd; e.resp = rs; e.mis = mi; e.tmo = tm; e.lat = lat; e.due = 0;
    return e;
  endfunction

  // Drive a command, wait (bounded) for acceptance, push the expected response.
  task automatic issue(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] m, input exp_t e);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_mask = m;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 64'(cmd_ready), 64'(1));
    e.due = cyc + e.lat;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_wait_expired", 64'(sb.size()), 64'(0));
  endtask

  task automatic chk_axi_quiet(input string tag);
    chk({tag, "_awvalid"}, 64'(M_AXI_AWVALID), 64'(0));
    chk({tag, "_wvalid"},  64'(M_AXI_WVALID),  64'(0));
    chk({tag, "_arvalid"}, 64'(M_AXI_ARVALID), 64'(0));
    chk({tag, "_bready"},  64'(M_AXI_BREADY),  64'(0));
    chk({tag, "_rready"},  64'(M_AXI_RREADY),  64'(0));
  endtask

  task automatic chk_cnt(input string tag, input int w, input int r, input int e);
    chk({tag, "_wr_count"},  64'(wr_count),  64'(w));
    chk({tag, "_rd_count"},  64'(rd_count),  64'(r));
    chk({tag, "_err_count"}, 64'(err_count), 64'(e));
  endtask

  // Monitor: pops the scoreboard on every rsp_valid pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (sb.size() == 0) chk("unexpected_rsp", 64'(1), 64'(0));
        else begin
          e = sb.pop_front();
          chk("rsp_rdata",    64'(rsp_rdata),    64'(e.rdata));
          chk("rsp_resp",     64'(rsp_resp),     64'(e.resp));
          chk("rsp_mismatch", 64'(rsp_mismatch), 64'(e.mis));
          chk("rsp_timeout",  64'(rsp_timeout),  64'(e.tmo));
          if (e.lat >= 0) chk("rsp_latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  // Reactive slave: evaluates at #2 after each edge; *_f predicts the next-edge handshake.
  initial begin : slave
    bit          have_aw, have_w, have_ar, aw_f, w_f, ar_f, b_f, r_f, p_awv, p_rst;
    logic [11:0] aw_a, ar_a, p_awa;
    logic [31:0] w_d;
    logic [3:0]  w_s;
    int          aw_c, w_c;
    have_aw = 0; have_w = 0; have_ar = 0; aw_f = 0; w_f = 0; ar_f = 0; b_f = 0; r_f = 0;
    p_awv = 0; p_rst = 1; aw_a = '0; ar_a = '0; p_awa = '0; w_d = '0; w_s = '0; aw_c = 0; w_c = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = '0;
    forever begin
      @(posedge clk); #2;
      if (p_rst) begin aw_f = 0; w_f = 0; ar_f = 0; b_f = 0; r_f = 0; end
      if (p_awv && !aw_f && !p_rst && !halted)
        chk("aw_hold", 64'({M_AXI_AWVALID, M_AXI_AWADDR}), 64'({1'b1, p_awa}));
      if (aw_f) have_aw = 1;
      if (w_f) begin
        have_w = 1;
        chk("w_drop", 64'(M_AXI_WVALID), 64'(0));
      end
      if (ar_f) have_ar = 1;
      if (b_f) begin M_AXI_BVALID = 0; n_b++; end
      if (r_f) M_AXI_RVALID = 0;
      if (rst) begin
        have_aw = 0; have_w = 0; have_ar = 0; M_AXI_BVALID = 0; M_AXI_RVALID = 0;
      end
      if (have_aw && have_w && !M_AXI_BVALID && !b_never) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) mem[aw_a[11:2]][8*b +: 8] = w_d[8*b +: 8];
        M_AXI_BVALID = 1; M_AXI_BRESP = b_resp_cfg; have_aw = 0; have_w = 0;
      end
      if (have_ar && !M_AXI_RVALID) begin
        M_AXI_RVALID = 1; M_AXI_RDATA = mem[ar_a[11:2]]; M_AXI_RRESP = r_resp_cfg; have_ar = 0;
      end
      if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_c >= aw_delay); aw_c++; end
      else begin M_AXI_AWREADY = 0; aw_c = 0; end
      if (M_AXI_WVALID) begin M_AXI_WREADY = (w_c >= w_delay); w_c++; end
      else begin M_AXI_WREADY = 0; w_c = 0; end
      M_AXI_ARREADY = M_AXI_ARVALID;
      aw_f = M_AXI_AWVALID && M_AXI_AWREADY;
      if (aw_f) aw_a = M_AXI_AWADDR;
      w_f = M_AXI_WVALID && M_AXI_WREADY;
      if (w_f) begin w_d = M_AXI_WDATA; w_s = M_AXI_WSTRB; end
      ar_f = M_AXI_ARVALID && M_AXI_ARREADY;
      if (ar_f) ar_a = M_AXI_ARADDR;
      b_f = M_AXI_BVALID && M_AXI_BREADY;
      r_f = M_AXI_RVALID && M_AXI_RREADY;
      p_awv = M_AXI_AWVALID; p_awa = M_AXI_AWADDR; p_rst = rst;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0; cmd_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    chk_axi_quiet("rst");
    chk_cnt("rst", 0, 0, 0);
    rst = 0;
    @(negedge clk);
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    // Zero-wait write: rsp at N+3
    issue(1, 12'h000, 32'h00100113, 4'hF, 32'h0, mk(32'h0, 2'b00, 0, 0, 3));
    wait_rsp();
    chk_cnt("wr1", 1, 0, 0);
    chk("mem_000", 64'(mem[0]), 64'(32'h00100113));

    // AWREADY three cycles after WREADY: rsp at N+6, one B
    aw_delay = 3;
    issue(1, 12'h004, 32'h11223344, 4'hF, 32'h0, mk(32'h0, 2'b00, 0, 0, 6));
    wait_rsp();
    aw_delay = 0;
    chk("one_b_per_write", 64'(n_b), 64'(2));
    chk("mem_004", 64'(mem[1]), 64'(32'h11223344));

    // Write then masked read-compare, pass then fail
    issue(1, 12'h800, 32'hdeadbeef, 4'hF, 32'h0, mk(32'h0, 2'b00, 0, 0, 3));
    issue(0, 12'h800, 32'hdeadbeef, 4'h0, 32'hFFFFFFFF, mk(32'hdeadbeef, 2'b00, 0, 0, 3));
    issue(0, 12'h800, 32'hdeadbeee, 4'h0, 32'hFFFFFFFF, mk(32'hdeadbeef, 2'b00, 1, 0, 3));
    wait_rsp();
    chk_cnt("rd_cmp", 3, 2, 1);

    // SLVERR on read with compare disabled
    r_resp_cfg = 2'b10;
    issue(0, 12'h000, 32'h12345678, 4'h0, 32'h0, mk(32'h00100113, 2'b10, 0, 0, 3));
    wait_rsp();
    r_resp_cfg = 2'b00;
    chk_cnt("rresp_err", 3, 3, 2);

    // Back-to-back writes drive wr_count into saturation (3 + 20 > 15)
    for (int i = 0; i < 20; i++)
      issue(1, 12'h100, 32'(i), 4'hF, 32'h0, mk(32'h0, 2'b00, 0, 0, 3));
    wait_rsp();
    chk_cnt("sat", 15, 3, 2);

    // rst during WRESP: everything quiet on the next cycle
    b_never = 1;
    issue(1, 12'h020, 32'h0, 4'hF, 32'h0, mk(32'h0, 2'b00, 0, 0, -1));
    n = 0;
    while (!M_AXI_BREADY && n < 20) begin @(posedge clk); #1; n++; end
    chk("reached_wresp", 64'(M_AXI_BREADY), 64'(1));
    rst = 1;
    @(posedge clk); #1;
    sb.delete();
    chk_axi_quiet("mid_rst");
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk_cnt("mid_rst", 0, 0, 0);
    rst = 0;
    @(posedge clk); #1;

    // BVALID never arrives: timeout fires when the counter reaches TIMEOUT
    issue(1, 12'h030, 32'h55aa55aa, 4'hF, 32'h0, mk(32'h0, 2'b10, 0, 1, TO + 2));
    wait_rsp();
    chk("halted_set", 64'(halted), 64'(1));
    chk("halted_busy", 64'(busy), 64'(1));
    chk_axi_quiet("halt");
    chk_cnt("halt", 0, 0, 1);
    cmd_valid = 1; cmd_write = 1;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (cmd_ready) n++;
    end
    cmd_valid = 0;
    chk("halt_cmd_ready_cycles", 64'(n), 64'(0));
    rst = 1;
    @(posedge clk); #1;
    chk("post_halt_rst_halted", 64'(halted), 64'(0));
    chk_cnt("post_halt_rst", 0, 0, 0);
    rst = 0;
    b_never = 0;
    @(negedge clk);
    chk("post_halt_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    // Partial strobe write then read back
    issue(1, 12'h010, 32'hCAFEF00D, 4'h3, 32'h0, mk(32'h0, 2'b00, 0, 0, 3));
    issue(0, 12'h010, 32'h0000F00D, 4'h0, 32'hFFFFFFFF, mk(32'h0000F00D, 2'b00, 0, 0, 3));
    wait_rsp();
    chk_cnt("strb", 1, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
